// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   state_t    : fetch-stage control state (IDLE, RUN, HALTED)
//   HALT_INSTR : instruction word that stops the pipeline
//   NOP_INSTR  : bubble presented to IF/ID when not fetching
//   PC_STEP    : byte increment between sequential instructions
package if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int unsigned PC_STEP    = 4;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: debug-unit program load/control, hazard and redirect
// inputs from ID, and the fetch outputs consumed by IF/ID and debug readout.
//   master : debug unit / ID side (drives controls, observes fetch outputs)
//   slave  : the fetch stage itself
interface if_fetch_stage_if #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_DEPTH = 256
);
  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);

  logic              i_load_we;
  logic [ADDR_W-1:0] i_load_addr;
  logic [NBITS-1:0]  i_load_data;
  logic              i_start;
  logic              i_restart;
  logic              i_enable;
  logic              i_stall;
  logic              i_pc_src;
  logic [NBITS-1:0]  i_pc_target;
  logic [NBITS-1:0]  o_instruction;
  logic [NBITS-1:0]  o_pc;
  logic [NBITS-1:0]  o_pc_current;
  logic [NBITS-1:0]  o_fetch_count;
  logic              o_halt;

  modport master (
    output i_load_we, i_load_addr, i_load_data, i_start, i_restart,
           i_enable, i_stall, i_pc_src, i_pc_target,
    input  o_instruction, o_pc, o_pc_current, o_fetch_count, o_halt
  );

  modport slave (
    input  i_load_we, i_load_addr, i_load_data, i_start, i_restart,
           i_enable, i_stall, i_pc_src, i_pc_target,
    output o_instruction, o_pc, o_pc_current, o_fetch_count, o_halt
  );

endinterface

// File: rtl/if_instr_mem.sv
// Word-addressed instruction memory: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   i_clk      : write clock
//   i_we       : write strobe
//   i_waddr    : write word index
//   i_wdata    : write data
//   i_raddr    : read word index
//   o_rdata_c  : combinational read data
module if_instr_mem #(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_waddr,
  input  logic [NBITS-1:0]             i_wdata,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_raddr,
  output logic [NBITS-1:0]             o_rdata_c
);

  logic [NBITS-1:0] mem [MEM_DEPTH];

  // Program load port
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Fetch port
  assign o_rdata_c = mem[i_raddr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, the program memory, the run/halt control and a fetch
// counter. Instruction and PC+4 are presented combinationally for the
// IF/ID register.
//   i_clk    : system clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : fetch-stage interface (slave side), see if_fetch_stage_if
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned NBITS     = 32,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  if_fetch_stage_if.slave   bus
);

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [NBITS-1:0] STEP_W = NBITS'(PC_STEP);
  localparam logic [NBITS-1:0] HALT_W = NBITS'(HALT_INSTR);
  localparam logic [NBITS-1:0] NOP_W  = NBITS'(NOP_INSTR);

  state_t            state_q, state_d;
  logic [NBITS-1:0]  pc_q, pc_d;
  logic [NBITS-1:0]  cnt_q, cnt_d;
  logic              halt_q;

  logic [ADDR_W-1:0] fetch_idx_c;
  logic [NBITS-1:0]  fetch_word_c;
  logic              mem_we_c;
  logic              advance_c;
  logic              halt_hit_c;

  // Word index ignores the byte offset; upper PC bits alias onto the memory
  assign fetch_idx_c = pc_q[ADDR_W+1:2];

  // Program may only be rewritten while the pipeline is not running
  assign mem_we_c = bus.i_load_we & (state_q == IDLE);

  if_instr_mem #(
    .NBITS     (NBITS),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_we      (mem_we_c),
    .i_waddr   (bus.i_load_addr),
    .i_wdata   (bus.i_load_data),
    .i_raddr   (fetch_idx_c),
    .o_rdata_c (fetch_word_c)
  );

  // Enable gates everything; a redirect still moves the PC through a stall
  assign advance_c  = (state_q == RUN) & bus.i_enable
                    & (bus.i_pc_src | ~bus.i_stall);

  // A HALT on the wrong path (redirect in the same cycle) is discarded
  assign halt_hit_c = advance_c & ~bus.i_pc_src & (fetch_word_c == HALT_W);

  // Next-state, PC and counter update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        pc_d = '0;
        if (bus.i_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (advance_c) begin
          cnt_d = cnt_q + NBITS'(1);
          if (halt_hit_c) begin
            state_d = HALTED;
          end else if (bus.i_pc_src) begin
            pc_d = bus.i_pc_target;
          end else begin
            pc_d = pc_q + STEP_W;
          end
        end
      end
      HALTED: begin
        if (bus.i_restart) begin
          state_d = IDLE;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      halt_q  <= (state_d == HALTED);
    end
  end

  // The HALT word itself is shown while in RUN; NOP once halted
  assign bus.o_instruction = (state_q == RUN) ? fetch_word_c : NOP_W;
  assign bus.o_pc          = pc_q + STEP_W;
  assign bus.o_pc_current  = pc_q;
  assign bus.o_fetch_count = cnt_q;
  assign bus.o_halt        = halt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: each stimulus cycle pushes the
// expected outputs from a behavioural model; a monitor pops and compares.
module tb_if_fetch_stage;

  localparam int unsigned NBITS = 32;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        rst_n;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        start;
    logic        restart;
    logic        enable;
    logic        stall;
    logic        pc_src;
    logic [31:0] target;
  } stim_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_cur;
    logic [31:0] cnt;
    logic        halt;
  } exp_t;

  logic clk;
  logic rst_n;

  if_fetch_stage_if #(.NBITS(NBITS), .MEM_DEPTH(DEPTH)) bus ();

  if_fetch_stage #(.NBITS(NBITS), .MEM_DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

  // Behavioural model: mode 0 = idle, 1 = running, 2 = halted
  logic [31:0] m_mem [DEPTH];
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s        = '0;
    s.rst_n  = 1'b1;
    s.enable = 1'b1;
    return s;
  endfunction

  // One clock of stimulus: apply inputs, predict visible outputs, advance model
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst_n            = s.rst_n;
    bus.i_load_we    = s.we;
    bus.i_load_addr  = s.addr;
    bus.i_load_data  = s.data;
    bus.i_start      = s.start;
    bus.i_restart    = s.restart;
    bus.i_enable     = s.enable;
    bus.i_stall      = s.stall;
    bus.i_pc_src     = s.pc_src;
    bus.i_pc_target  = s.target;
    if (!s.rst_n) begin
      m_mode = 0;
      m_pc   = '0;
      m_cnt  = '0;
    end
    e.instr  = (m_mode == 1) ? m_mem[m_pc[9:2]] : 32'h0;
    e.pc     = m_pc + 32'd4;
    e.pc_cur = m_pc;
    e.cnt    = m_cnt;
    e.halt   = (m_mode == 2);
    exp_q.push_back(e);
    pushed++;
    if (s.rst_n) begin
      case (m_mode)
        0: begin
          if (s.we) m_mem[s.addr] = s.data;
          if (s.start) m_mode = 1;
        end
        1: begin
          if (s.enable && (s.pc_src || !s.stall)) begin
            m_cnt = m_cnt + 32'd1;
            if (s.pc_src) m_pc = s.target;
            else if (m_mem[m_pc[9:2]] == HALT) m_mode = 2;
            else m_pc = m_pc + 32'd4;
          end
        end
        default: begin
          if (s.restart) begin
            m_mode = 0;
            m_pc   = '0;
            m_cnt  = '0;
          end
        end
      endcase
    end
  endtask

  task automatic do_reset();
    stim_t s;
    s       = quiet();
    s.rst_n = 1'b0;
    step(s);
  endtask

  task automatic load(input int unsigned addr, input logic [31:0] data);
    stim_t s;
    s      = quiet();
    s.we   = 1'b1;
    s.addr = 8'(addr);
    s.data = data;
    step(s);
  endtask

  task automatic start();
    stim_t s;
    s       = quiet();
    s.start = 1'b1;
    step(s);
  endtask

  task automatic run(input int unsigned n);
    for (int i = 0; i < int'(n); i++) step(quiet());
  endtask

  task automatic ctl(input logic en, input logic st, input logic src, input logic [31:0] tgt);
    stim_t s;
    s        = quiet();
    s.enable = en;
    s.stall  = st;
    s.pc_src = src;
    s.target = tgt;
    step(s);
  endtask

  // Monitor: compare every presented output set against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
        chk("instruction", bus.o_instruction, e.instr);
        chk("pc_plus4",    bus.o_pc,          e.pc);
        chk("pc_current",  bus.o_pc_current,  e.pc_cur);
        chk("fetch_count", bus.o_fetch_count, e.cnt);
        chk("halt",        32'(bus.o_halt),   32'(e.halt));
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    bus.i_load_we = 1'b0; bus.i_load_addr = '0; bus.i_load_data = '0;
    bus.i_start = 1'b0; bus.i_restart = 1'b0; bus.i_enable = 1'b0;
    bus.i_stall = 1'b0; bus.i_pc_src = 1'b0; bus.i_pc_target = '0;
    m_mode = 0; m_pc = '0; m_cnt = '0;

    do_reset();
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++)
      load(i, 32'h2100_0000 ^ (32'(i) * 32'h0001_0101));

    // Sequential fetch of a short program
    for (int i = 0; i < 4; i++) load(i, 32'h2001_0001 + 32'(i));
    start();
    run(5);

    // Stall holds PC and count; enable low freezes even a redirect
    do_reset(); start();
    run(2);
    ctl(1'b1, 1'b1, 1'b0, 32'h0);
    ctl(1'b1, 1'b1, 1'b0, 32'h0);
    ctl(1'b0, 1'b0, 1'b1, 32'h80);
    run(2);

    // Redirect beats stall; target low bits kept; PC wrap at top of space
    do_reset(); start();
    run(1);
    ctl(1'b1, 1'b1, 1'b1, 32'h40);
    run(1);
    ctl(1'b1, 1'b0, 1'b1, 32'h43);
    run(1);
    ctl(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    run(2);

    // HALT at word 2: shown once, then frozen; restart returns to IDLE
    do_reset();
    load(2, HALT);
    start();
    run(6);
    s = quiet(); s.restart = 1'b1; step(s);
    run(2);

    // Wrong-path HALT is skipped; stalled HALT waits for the advance cycle
    start();
    run(2);
    ctl(1'b1, 1'b0, 1'b1, 32'h0);
    run(2);
    ctl(1'b1, 1'b1, 1'b0, 32'h0);
    ctl(1'b1, 1'b1, 1'b0, 32'h0);
    run(3);
    s = quiet(); s.restart = 1'b1; step(s);

    // Writes ignored in RUN; async reset mid-RUN keeps program memory
    start();
    run(1);
    load(0, 32'hDEAD_BEEF);
    load(1, 32'hDEAD_BEEF);
    run(1);
    do_reset();
    run(1);
    ctl(1'b1, 1'b0, 1'b1, 32'h0);
    start();
    run(3);

    // Randomized traffic concentrated on a small program region
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      s.rst_n   = ($urandom_range(0, 199) != 0);
      s.we      = s.rst_n && ($urandom_range(0, 2) == 0);
      s.addr    = 8'($urandom_range(0, 15));
      s.data    = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
      s.start   = ($urandom_range(0, 3) == 0);
      s.restart = ($urandom_range(0, 3) == 0);
      s.enable  = ($urandom_range(0, 7) != 0);
      s.stall   = ($urandom_range(0, 3) == 0);
      s.pc_src  = ($urandom_range(0, 5) == 0);
      s.target  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
      step(s);
    end

    repeat (3) @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("samples_popped", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
